// File: rtl/fx_bus_master.sv
// Purpose: parses a byte-wide command stream into fx-bus register writes/reads and returns read data as bytes.
// Latency: fx_wr one cycle after each data byte handshake; read response valid two cycles after fx_rd (3 cycles/byte min).
// Backpressure: cmd_rdy drops for the whole read phase; rsp_vld/rsp_data are held until rsp_rdy.
module fx_bus_master (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   output logic [7:0]  rsp_data,
   output logic        rsp_vld,
   input  logic        rsp_rdy,
   output logic [21:0] fx_waddr,
   output logic        fx_wr,
   output logic [7:0]  fx_data,
   output logic [21:0] fx_raddr,
   output logic        fx_rd,
   input  logic [7:0]  fx_q,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   localparam logic [7:0] OPC_WR = 8'h57;
   localparam logic [7:0] OPC_RD = 8'h52;

   typedef enum logic [3:0] {
      S_IDLE,
      S_A2,
      S_A1,
      S_A0,
      S_LEN,
      S_WDATA,
      S_RD_REQ,
      S_RD_WAIT,
      S_RD_RSP
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Packet context: direction, device id, running offset, remaining count minus one.
   logic        r_dir_wr;
   logic [5:0]  r_dev;
   logic [15:0] r_addr;
   logic [7:0]  r_len;

   // Registered bus and response outputs.
   logic        r_fx_wr;
   logic [21:0] r_fx_waddr;
   logic [7:0]  r_fx_data;
   logic        r_fx_rd;
   logic [21:0] r_fx_raddr;
   logic        r_rsp_vld;
   logic [7:0]  r_rsp_data;
   logic [7:0]  r_err_cnt;

   logic        w_cmd_rdy;
   logic        w_cmd_acc;
   logic        w_is_opc;
   logic        w_last;
   logic        w_rsp_acc;
   logic        w_rd_start;
   logic [15:0] w_addr_inc;
   logic [15:0] w_rd_addr;

   assign w_cmd_acc  = cmd_vld & w_cmd_rdy;
   assign w_is_opc   = (cmd_data == OPC_WR) || (cmd_data == OPC_RD);
   assign w_last     = (r_len == 8'd0);
   assign w_rsp_acc  = (r_state == S_RD_RSP) & r_rsp_vld & rsp_rdy;
   // Offset wraps within the 16-bit register space; dev_id is never touched.
   assign w_addr_inc = r_addr + 16'd1;

   // A read strobe is launched on the LEN byte of a read packet, or when an
   // accepted response leaves more bytes to fetch. The strobe is registered, so
   // fx_rd is high during the RD_REQ cycle itself.
   assign w_rd_start = ((r_state == S_LEN) & w_cmd_acc & ~r_dir_wr) |
                       (w_rsp_acc & ~w_last);
   assign w_rd_addr  = (r_state == S_RD_RSP) ? w_addr_inc : r_addr;

   // State register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode: header states step on each accepted byte, read states are self-timed.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_cmd_acc && w_is_opc) w_state_nxt = S_A2;
         S_A2:      if (w_cmd_acc) w_state_nxt = S_A1;
         S_A1:      if (w_cmd_acc) w_state_nxt = S_A0;
         S_A0:      if (w_cmd_acc) w_state_nxt = S_LEN;
         S_LEN:     if (w_cmd_acc) w_state_nxt = r_dir_wr ? S_WDATA : S_RD_REQ;
         S_WDATA:   if (w_cmd_acc && w_last) w_state_nxt = S_IDLE;
         S_RD_REQ:  w_state_nxt = S_RD_WAIT;
         S_RD_WAIT: w_state_nxt = S_RD_RSP;
         S_RD_RSP:  if (w_rsp_acc) w_state_nxt = w_last ? S_IDLE : S_RD_REQ;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Command stream is only consumed while parsing a header or streaming write data.
   always_comb begin
      w_cmd_rdy = 1'b0;
      case (r_state)
         S_IDLE, S_A2, S_A1, S_A0, S_LEN, S_WDATA: w_cmd_rdy = 1'b1;
         default:                                  w_cmd_rdy = 1'b0;
      endcase
   end

   // Datapath: header capture, write/read strobes, response holding and error count.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_dir_wr   <= 1'b0;
         r_dev      <= 6'd0;
         r_addr     <= 16'd0;
         r_len      <= 8'd0;
         r_fx_wr    <= 1'b0;
         r_fx_waddr <= 22'd0;
         r_fx_data  <= 8'd0;
         r_fx_rd    <= 1'b0;
         r_fx_raddr <= 22'd0;
         r_rsp_vld  <= 1'b0;
         r_rsp_data <= 8'd0;
         r_err_cnt  <= 8'd0;
      end else begin
         // Strobes are single-cycle pulses unless re-armed below.
         r_fx_wr <= 1'b0;
         r_fx_rd <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_cmd_acc) begin
                  if (w_is_opc) begin
                     r_dir_wr <= (cmd_data == OPC_WR);
                  end else if (r_err_cnt != 8'hFF) begin
                     r_err_cnt <= r_err_cnt + 8'd1;
                  end
               end
            end
            S_A2: begin
               // Bits [7:6] of the top address byte carry no meaning.
               if (w_cmd_acc) r_dev <= cmd_data[5:0];
            end
            S_A1: begin
               if (w_cmd_acc) r_addr[15:8] <= cmd_data;
            end
            S_A0: begin
               if (w_cmd_acc) r_addr[7:0] <= cmd_data;
            end
            S_LEN: begin
               if (w_cmd_acc) r_len <= cmd_data;
            end
            S_WDATA: begin
               if (w_cmd_acc) begin
                  r_fx_wr    <= 1'b1;
                  r_fx_waddr <= {r_dev, r_addr};
                  r_fx_data  <= cmd_data;
                  r_addr     <= w_addr_inc;
                  r_len      <= r_len - 8'd1;
               end
            end
            S_RD_WAIT: begin
               // fx_q is valid in the cycle after fx_rd, which is this one.
               r_rsp_data <= fx_q;
               r_rsp_vld  <= 1'b1;
            end
            S_RD_RSP: begin
               if (w_rsp_acc) begin
                  r_rsp_vld <= 1'b0;
                  r_addr    <= w_addr_inc;
                  r_len     <= r_len - 8'd1;
               end
            end
            default: begin
            end
         endcase

         if (w_rd_start) begin
            r_fx_rd    <= 1'b1;
            r_fx_raddr <= {r_dev, w_rd_addr};
         end
      end
   end

   assign cmd_rdy  = w_cmd_rdy;
   assign busy     = (r_state != S_IDLE);
   assign fx_wr    = r_fx_wr;
   assign fx_waddr = r_fx_waddr;
   assign fx_data  = r_fx_data;
   assign fx_rd    = r_fx_rd;
   assign fx_raddr = r_fx_raddr;
   assign rsp_vld  = r_rsp_vld;
   assign rsp_data = r_rsp_data;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_fx_bus_master.sv
// Bench for fx_bus_master: write-path vectors from a table, read/reset corners as sequences.
// Slave model returns the low address byte for dev_id 1 and 0 otherwise, one cycle after fx_rd.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
module tb_fx_bus_master;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic [7:0]  cmd_data;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [7:0]  rsp_data;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [21:0] fx_waddr;
   logic        fx_wr;
   logic [7:0]  fx_data;
   logic [21:0] fx_raddr;
   logic        fx_rd;
   logic [7:0]  fx_q = 8'h00;
   logic        busy;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   fx_bus_master dut (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .cmd_data (cmd_data),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .rsp_data (rsp_data),
      .rsp_vld  (rsp_vld),
      .rsp_rdy  (rsp_rdy),
      .fx_waddr (fx_waddr),
      .fx_wr    (fx_wr),
      .fx_data  (fx_data),
      .fx_raddr (fx_raddr),
      .fx_rd    (fx_rd),
      .fx_q     (fx_q),
      .busy     (busy),
      .err_cnt  (err_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   // Slave model: data only during the cycle right after fx_rd.
   always @(posedge clk_sys) begin
      fx_q <= (fx_rd && fx_raddr[21:16] == 6'h01) ? fx_raddr[7:0] : 8'h00;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      cmd_vld  = 1'b1;
      cmd_data = b;
      tick();
      cmd_vld  = 1'b0;
   endtask

   typedef struct {
      logic        vld;
      logic [7:0]  dat;
      logic        exp_rdy;
      logic        exp_busy;
      logic        exp_wr;
      logic [21:0] exp_waddr;
      logic [7:0]  exp_wdat;
      logic [7:0]  exp_err;
   } vec_t;

   vec_t vecs[24];

   // Read-sequence observations.
   int          rd_cyc[$];
   logic [21:0] rd_addr[$];
   logic [7:0]  rsp_got[$];
   int          cmdrdy_viol;
   int          overlap_viol;
   int          hold_viol;
   logic        rd_done;

   task automatic do_read(input logic [5:0] dev, input logic [15:0] addr,
                          input logic [7:0] len, input int stall);
      int          vcnt;
      logic [7:0]  held;
      logic        pending;
      rd_cyc.delete();
      rd_addr.delete();
      rsp_got.delete();
      cmdrdy_viol  = 0;
      overlap_viol = 0;
      hold_viol    = 0;
      rd_done      = 1'b0;
      vcnt         = 0;
      held         = 8'h00;
      pending      = 1'b0;
      rsp_rdy      = (stall == 0);
      send_byte(8'h52);
      send_byte({2'b11, dev});   // top bits must be ignored
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      send_byte(len);
      // Offer junk bytes throughout the read phase; none may be consumed.
      cmd_vld  = 1'b1;
      cmd_data = 8'hA5;
      for (int c = 0; c < 400; c++) begin
         if (!busy) begin
            rd_done = 1'b1;
            break;
         end
         if (cmd_rdy) cmdrdy_viol++;
         if (pending && !rsp_vld) hold_viol++;
         if (fx_rd) begin
            rd_cyc.push_back(c);
            rd_addr.push_back(fx_raddr);
            if (rsp_vld) overlap_viol++;
         end
         if (rsp_vld) begin
            vcnt++;
            if (vcnt == 1) held = rsp_data;
            else if (rsp_data !== held) hold_viol++;
            rsp_rdy = (vcnt > stall);
            if (rsp_rdy) rsp_got.push_back(rsp_data);
         end else begin
            vcnt    = 0;
            rsp_rdy = (stall == 0);
         end
         pending = rsp_vld && !rsp_rdy;
         tick();
      end
      cmd_vld = 1'b0;
      rsp_rdy = 1'b1;
   endtask

   initial begin
      // Write-path vectors: inputs for one edge, expected outputs after it.
      // Single write 57 01 00 80 00 AA
      vecs[0]  = '{1'b1, 8'h57, 1'b1, 1'b1, 1'b0, 22'h000000, 8'h00, 8'd0};
      vecs[1]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 22'h000000, 8'h00, 8'd0};
      vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 22'h000000, 8'h00, 8'd0};
      vecs[3]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 22'h000000, 8'h00, 8'd0};
      vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 22'h000000, 8'h00, 8'd0};
      vecs[5]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 22'h010080, 8'hAA, 8'd0};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 22'h010080, 8'hAA, 8'd0};
      // Bad opcode 33 then write 57 01 00 81 00 5A
      vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[8]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[9]  = '{1'b1, 8'h57, 1'b1, 1'b1, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[10] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[12] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[13] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 22'h010080, 8'hAA, 8'd1};
      vecs[14] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 22'h010081, 8'h5A, 8'd1};
      // Wrap 57 01 FF (gap) FF 01 11 22
      vecs[15] = '{1'b1, 8'h57, 1'b1, 1'b1, 1'b0, 22'h010081, 8'h5A, 8'd1};
      vecs[16] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 22'h010081, 8'h5A, 8'd1};
      vecs[17] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 22'h010081, 8'h5A, 8'd1};
      vecs[18] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 22'h010081, 8'h5A, 8'd1};
      vecs[19] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 22'h010081, 8'h5A, 8'd1};
      vecs[20] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 22'h010081, 8'h5A, 8'd1};
      vecs[21] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 22'h01FFFF, 8'h11, 8'd1};
      vecs[22] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 22'h010000, 8'h22, 8'd1};
      vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 22'h010000, 8'h22, 8'd1};

      rst_n    = 1'b0;
      cmd_vld  = 1'b0;
      cmd_data = 8'h00;
      rsp_rdy  = 1'b1;
      tick();
      tick();
      check("reset_state",
            {fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, rsp_vld, rsp_data, busy, cmd_rdy, err_cnt},
            {1'b0, 22'h0, 8'h0, 1'b0, 22'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h0});
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 24; i++) begin
         cmd_vld  = vecs[i].vld;
         cmd_data = vecs[i].dat;
         tick();
         check($sformatf("vec[%0d] rdy/busy/wr/waddr/data/rd/rvld/err", i),
               {cmd_rdy, busy, fx_wr, fx_waddr, fx_data, fx_rd, rsp_vld, err_cnt},
               {vecs[i].exp_rdy, vecs[i].exp_busy, vecs[i].exp_wr, vecs[i].exp_waddr,
                vecs[i].exp_wdat, 1'b0, 1'b0, vecs[i].exp_err});
      end
      cmd_vld = 1'b0;

      // Read of absent dev_id returns 0 and is not an error.
      do_read(6'h3F, 16'h0010, 8'h00, 0);
      check("absent_done", rd_done, 1'b1);
      check("absent_nrsp", rsp_got.size(), 1);
      check("absent_data", rsp_got[0], 8'h00);
      check("absent_raddr", rd_addr[0], 22'h3F0010);

      // Burst read of two bytes with rsp_rdy high.
      do_read(6'h01, 16'h0080, 8'h01, 0);
      check("rd_done", rd_done, 1'b1);
      check("rd_nstrobe", rd_cyc.size(), 2);
      check("rd_addr0", rd_addr[0], 22'h010080);
      check("rd_addr1", rd_addr[1], 22'h010081);
      check("rd_spacing", rd_cyc[1] - rd_cyc[0], 3);
      check("rd_nrsp", rsp_got.size(), 2);
      check("rd_data0", rsp_got[0], 8'h80);
      check("rd_data1", rsp_got[1], 8'h81);
      check("rd_cmdrdy_low", cmdrdy_viol, 0);
      check("rd_no_overlap", overlap_viol, 0);

      // Same read with rsp_rdy held low for 10 cycles per response.
      do_read(6'h01, 16'h0080, 8'h01, 10);
      check("bp_done", rd_done, 1'b1);
      check("bp_hold", hold_viol, 0);
      check("bp_no_early_rd", overlap_viol, 0);
      check("bp_spacing", rd_cyc[1] - rd_cyc[0], 13);
      check("bp_nrsp", rsp_got.size(), 2);
      check("bp_data0", rsp_got[0], 8'h80);
      check("bp_data1", rsp_got[1], 8'h81);
      check("bp_cmdrdy_low", cmdrdy_viol, 0);
      check("err_after_reads", err_cnt, 8'd1);

      // Error counter saturates.
      cmd_vld  = 1'b1;
      cmd_data = 8'hFF;
      for (int i = 0; i < 300; i++) tick();
      cmd_vld = 1'b0;
      check("err_saturate", err_cnt, 8'hFF);
      check("err_idle", busy, 1'b0);

      // Reset in the middle of a 4-byte write.
      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h40);
      send_byte(8'h03);
      send_byte(8'hD1);
      check("rst_first_wr", {fx_wr, fx_waddr, fx_data}, {1'b1, 22'h010040, 8'hD1});
      cmd_vld  = 1'b1;
      cmd_data = 8'hD2;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs",
            {fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, rsp_vld, rsp_data, busy, cmd_rdy, err_cnt},
            {1'b0, 22'h0, 8'h0, 1'b0, 22'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h0});
      tick();
      cmd_data = 8'hD3;
      tick();
      check("rst_held_no_wr", {fx_wr, busy}, 2'b00);
      cmd_vld = 1'b0;
      rst_n   = 1'b1;
      begin
         int wr_seen;
         wr_seen = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (fx_wr) wr_seen++;
         end
         check("rst_no_further_wr", wr_seen, 0);
      end
      send_byte(8'h57);
      check("rst_opcode_accepted", {busy, err_cnt}, {1'b1, 8'h00});
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h00);
      send_byte(8'hC3);
      check("rst_next_packet", {fx_wr, fx_waddr, fx_data, busy}, {1'b1, 22'h021234, 8'hC3, 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fx_bus_master.md
# fx_bus_master

Command-stream to fx-bus bridge that sits directly upstream of every fx-bus register slave. A byte-wide command stream arrives on a valid/ready interface, typically from the USB/FX host FIFO front end. The block parses each packet into single or burst register writes and reads on the fx bus, and returns read data as a byte-wide response stream. It is the sole driver of fx_waddr/fx_wr/fx_data/fx_rd/fx_raddr. It consumes the OR-combined fx_q returned by the slaves.

## Interface
- No parameters.
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_data  in  8  command stream byte.
- cmd_vld  in  1  cmd_data valid.
- cmd_rdy  out  1  block accepts cmd_data; a byte transfers when cmd_vld & cmd_rdy.
- rsp_data  out  8  read response byte.
- rsp_vld  out  1  rsp_data valid; held until accepted.
- rsp_rdy  in  1  downstream accepts rsp_data.
- fx_waddr  out  22  write address; [21:16] = dev_id, [15:0] = register offset.
- fx_wr  out  1  single-cycle write strobe.
- fx_data  out  8  write data, valid with fx_wr.
- fx_raddr  out  22  read address.
- fx_rd  out  1  single-cycle read strobe.
- fx_q  in  8  read data from the slaves, valid exactly 1 cycle after fx_rd. Unaddressed slaves drive 0.
- busy  out  1  high whenever state != IDLE.
- err_cnt  out  8  count of rejected opcodes; saturates at 8'hFF.

## Operation
- Packet format:
  - OPC, ADDR2, ADDR1, ADDR0, LEN, then for writes LEN+1 data bytes.
  - OPC 8'h57 = write, 8'h52 = read.
  - Address = {ADDR2[5:0], ADDR1, ADDR0`}`; ADDR2[7:6] are ignored.
  - Transfer count N = LEN+1 (1..256).
- States: IDLE, A2, A1, A0, LEN, WDATA, RD_REQ, RD_WAIT, RD_RSP.
- IDLE:
  - On an accepted byte of 8'h57 or 8'h52, latch the direction and go to A2.
  - Any other byte is dropped, err_cnt increments (saturating), and the state stays IDLE.
- A2 -> A1 -> A0 -> LEN: each state advances on one accepted byte and loads the corresponding address byte or the count.
- LEN exit: go to WDATA for a write, RD_REQ for a read.
- WDATA, for each accepted byte:
  - Register fx_data = byte, fx_waddr = cur_addr, fx_wr = 1 for the next cycle.
  - Then increment cur_addr and decrement the remaining count.
  - After the N-th byte, go to IDLE.
- RD_REQ: drive fx_rd = 1 and fx_raddr = cur_addr for one cycle, then go to RD_WAIT.
- RD_WAIT: capture fx_q into rsp_data, set rsp_vld, go to RD_RSP.
- RD_RSP:
  - Hold rsp_vld/rsp_data until rsp_rdy.
  - On accept, increment cur_addr and decrement the remaining count.
  - Go to RD_REQ if bytes remain, else IDLE.
- cmd_rdy = 1 in IDLE, A2, A1, A0, LEN and WDATA; 0 in all read states. No bytes are consumed during a read burst.
- Address increment applies to [15:0] only and wraps 16'hFFFF -> 16'h0000. [21:16] are never altered within a packet.
- Reads of an absent dev_id return 8'h00 as the response byte; this is not an error.

## Timing
- Reset values:
  - state = IDLE.
  - fx_wr, fx_rd, rsp_vld = 0.
  - fx_waddr, fx_raddr, fx_data, rsp_data = 0.
  - err_cnt = 0, busy = 0.
  - cmd_rdy = 1, decoded from state IDLE.
- fx_wr and fx_rd are registered and are high for exactly 1 cycle per transfer. They are never high together.
- Write latency: fx_wr asserts the cycle after the data byte handshake. Back-to-back data bytes give back-to-back fx_wr pulses, so write throughput is 1 byte/cycle.
- Read latency:
  - fx_rd in cycle t.
  - fx_q sampled at the end of cycle t+1.
  - rsp_vld high from t+2.
  - Minimum of 3 cycles per read byte when rsp_rdy is held high.
- fx_waddr/fx_raddr hold their last value between strobes.
- Reset asserted mid-packet aborts immediately with no further strobes. The next byte after reset is treated as an opcode.

## Test plan
- Single write: stream 57 01 00 80 00 AA -> one fx_wr pulse with fx_waddr=22'h010080 and fx_data=8'hAA; busy returns to 0; err_cnt stays 0.
- Burst read, rsp_rdy=1, slave holds 80/81: stream 52 01 00 80 01 -> two fx_rd pulses at 22'h010080 then 22'h010081, each 3 cycles apart; responses 8'h80 then 8'h81; cmd_rdy low throughout the read phase.
- Back-pressure: same read with rsp_rdy low for 10 cycles -> rsp_vld and rsp_data stable for all 10 cycles; no second fx_rd until the first response is accepted.
- Bad opcode: stream 33 57 01 00 81 00 5A -> err_cnt = 1; the 8'h33 is dropped; a write of 8'h5A to 22'h010081 follows.
- Wrap: write stream 57 01 FF FF 01 11 22 -> fx_wr at 22'h01FFFF (data 11), then at 22'h010000 (data 22).
- Reset mid-burst: assert rst_n low during the 2nd byte of a 4-byte write -> no further fx_wr; all outputs take their reset values; a following full packet executes correctly.
